serial_sum_collector: RTL and testbench
=======================================

Name: serial_sum_collector

Overview:
- Downstream stage of the bit-serial summator; consumes its 1-bit LSB-first sum stream.
- Reassembles the stream into a parallel (reglength+1)-bit word.
- Presents the word on a valid/ready output port.
- Flags protocol violations: a new word starting before the previous word was accepted, or during a capture.

Parameters:
- reglength, 3, operand width of the upstream summator; the collected word is reglength+1 bits wide (legal range ≥1).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  single-cycle marker; high in the cycle where sum_in carries bit 0 of a new word.
- sum_in  input  1  serial sum bit, LSB first, one bit per clk.
- out_ready  input  1  consumer accepts out_data when high with out_valid.
- out_data  output  reglength+1  collected word.
- out_valid  output  1  out_data holds a complete word.
- busy  output  1  a capture is in progress (state SHIFT).
- overrun  output  1  sticky violation flag; cleared only by rst.

Behaviour:
- Reset (rst=1 at posedge): state IDLE; shift register, bit counter and out_data go to 0; out_valid=0, busy=0, overrun=0. Reset in any state aborts a partial word with no output.
- States: IDLE, SHIFT, HOLD. Encoding 2 bits: IDLE=0, SHIFT=1, HOLD=2.
- IDLE:
  - start=1: sample sum_in as bit 0, set count=1, go to SHIFT.
  - start=0: stay in IDLE; sum_in is ignored.
- SHIFT:
  - Each posedge: shift register shifts right and sum_in enters at the MSB (bit reglength); count increments.
  - When the bit sampled on this edge is bit reglength (count==reglength before the edge): load the assembled word into out_data, set out_valid=1, go to HOLD, clear count.
  - start=1 in SHIFT: ignored for capture; set overrun=1.
- Latency: start at edge E0 gives out_valid=1 after edge E0+reglength. Example: 4-bit word, valid after the 4th sampling edge.
- HOLD:
  - out_valid=1 and out_data stays stable.
  - out_ready=1 at posedge: handshake; out_valid=0 after this edge; go to IDLE.
  - start=1 with out_ready=1 in the same cycle: handshake completes and the new capture begins; sum_in is taken as bit 0, go to SHIFT.
  - start=1 with out_ready=0: start is dropped and overrun=1; stay in HOLD.
- busy = (state==SHIFT), registered together with the state.
- out_data changes only on the HOLD entry load. It is not cleared on handshake.
- Counter width: clog2(reglength+1) bits. It never exceeds reglength.

Optional Feature:
- Macro SERIAL_SUM_PARITY_EN.
- Defined:
  - Adds output port parity (1 bit), loaded together with out_data as the XOR of all collected bits; reset value 0.
  - Adds input parity_in (1 bit), sampled in the cycle after the last data bit while in HOLD with out_valid=1.
  - A mismatch sets sticky output parity_err; cleared by rst.
- Undefined: these ports and their logic do not exist; the block behaves exactly as above.

Decomposition:
- Shared package serial_sum_pkg:
  - state encodings ST_IDLE, ST_SHIFT, ST_HOLD;
  - word-width function sum_width(reglength)=reglength+1;
  - counter-width function.
- One sub-module, serial_bit_counter:
  - parameterised modulo counter with clk, rst, clear, inc;
  - outputs count and a last flag (count==limit-1).
  - Used by the FSM to detect the final bit.

Test Plan:
- Reset: hold rst=1 for 2 cycles mid-SHIFT (after 2 bits) → out_valid=0, busy=0, overrun=0, out_data=0, state IDLE. A subsequent clean word is collected correctly.
- Basic word, reglength=3, operands 5+6=11: start with sum_in sequence 1,1,0,1 on 4 consecutive edges → out_valid=1 after the 4th edge, out_data=4'b1011. busy=1 for edges 1–3.
- Backpressure: out_ready=0 for 5 cycles after valid → out_data stays 4'b1011 and out_valid stays 1. Raise out_ready → out_valid=0 next cycle.
- Back-to-back: start coincides with out_ready=1 in HOLD, new stream 0,0,1,0 → first word accepted, second word out_data=4'b0100. overrun stays 0.
- Overrun: start pulsed during SHIFT (bit 2), then again in HOLD with out_ready=0 → overrun=1 at both points and stays 1. The current word is unaffected (still 4'b1011).
- With SERIAL_SUM_PARITY_EN: word 1011 → parity=1. Drive parity_in=0 → parity_err=1. Repeat with parity_in=1 → parity_err stays 0 after reset.

Source files
------------

// File: rtl/serial_sum_pkg.sv
// serial_sum_pkg
// Shared definitions for the serial sum collector slice.
//   - sumState_t : capture FSM state encoding (IDLE=0, SHIFT=1, HOLD=2)
//   - sum_width  : width of the collected word for a given operand width
//   - cnt_width  : width of the bit counter needed to count 0..reglength
package serial_sum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } sumState_t;

    // The summator produces one carry bit beyond its operand width.
    function automatic int sum_width(input int reglength);
        return reglength + 1;
    endfunction

    // Counter has to reach reglength, so it needs clog2(reglength+1) bits.
    function automatic int cnt_width(input int reglength);
        return (reglength < 1) ? 1 : $clog2(reglength + 1);
    endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// serial_bit_counter
// Modulo-LIMIT up counter with synchronous reset and clear.
// Ports:
//   clk   - clock, state changes on posedge
//   rst   - synchronous active-high reset, count goes to 0
//   clear - synchronous clear, has priority over inc
//   inc   - advance the count by one, wrapping from LIMIT-1 to 0
//   count - current count value
//   last  - high while count == LIMIT-1
module serial_bit_counter #(
    parameter int LIMIT = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise step and wrap at LIMIT-1.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = (count_q == LAST_VAL) ? '0 : count_q + WIDTH'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LAST_VAL);

endmodule

// File: rtl/serial_sum_collector.sv
// serial_sum_collector
// Collects the LSB-first serial sum stream of the bit-serial summator into a
// (reglength+1)-bit word and offers it on a valid/ready port. Flags a start
// that arrives during a capture or while an unaccepted word is held.
// Ports:
//   clk        - clock, all state changes on posedge
//   rst        - synchronous active-high reset
//   start      - marks the cycle where sum_in carries bit 0 of a new word
//   sum_in     - serial sum bit, LSB first
//   out_ready  - consumer accepts out_data while out_valid is high
//   out_data   - collected word
//   out_valid  - out_data holds a complete word
//   busy       - capture in progress
//   overrun    - sticky protocol-violation flag, cleared only by rst
// Optional (macro SERIAL_SUM_PARITY_EN):
//   parity_in  - expected parity, sampled on the first edge in HOLD
//   parity     - XOR of the collected word, loaded with out_data
//   parity_err - sticky parity mismatch flag, cleared only by rst
module serial_sum_collector
    import serial_sum_pkg::*;
#(
    parameter int reglength = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            sum_in,
    input  logic                            out_ready,
`ifdef SERIAL_SUM_PARITY_EN
    input  logic                            parity_in,
    output logic                            parity,
    output logic                            parity_err,
`endif
    output logic [sum_width(reglength)-1:0] out_data,
    output logic                            out_valid,
    output logic                            busy,
    output logic                            overrun
);

    localparam int W  = sum_width(reglength);
    localparam int CW = cnt_width(reglength);

    sumState_t      state_q, state_d;
    logic [W-1:0]   shiftReg_q, shiftReg_d;
    logic [W-1:0]   outData_q, outData_d;
    logic           outValid_q, outValid_d;
    logic           busy_q, busy_d;
    logic           overrun_q, overrun_d;
    logic [W-1:0]   shifted;
    logic           cntInc;
    logic           cntClear;
    logic           cntLast;
    logic [CW-1:0]  bitCount;

    // Counts received bits; last marks that the bit arriving now is bit reglength.
    serial_bit_counter #(
        .LIMIT(reglength + 1),
        .WIDTH(CW)
    ) uBitCounter (
        .clk  (clk),
        .rst  (rst),
        .clear(cntClear),
        .inc  (cntInc),
        .count(bitCount),
        .last (cntLast)
    );

    // Right shift with sum_in entering at the MSB; after W shifts bit 0 of
    // the stream sits in bit 0 of the word.
    assign shifted = W'({sum_in, shiftReg_q} >> 1);

    // Capture FSM: next state, datapath loads and violation detection.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        outData_d  = outData_q;
        outValid_d = outValid_q;
        overrun_d  = overrun_q;
        cntInc     = 1'b0;
        cntClear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shiftReg_d = shifted;
                    cntInc     = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shiftReg_d = shifted;
                if (start) begin
                    overrun_d = 1'b1;
                end
                if (cntLast) begin
                    outData_d  = shifted;
                    outValid_d = 1'b1;
                    cntClear   = 1'b1;
                    state_d    = ST_HOLD;
                end else begin
                    cntInc = 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    state_d    = ST_IDLE;
                    if (start) begin
                        shiftReg_d = shifted;
                        cntInc     = 1'b1;
                        state_d    = ST_SHIFT;
                    end
                end else if (start) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                outValid_d = 1'b0;
            end
        endcase
        // Outside a capture the counter must sit at zero so the next word
        // starts counting from bit 0.
        if (state_q != ST_SHIFT && !cntInc && bitCount != '0) begin
            cntClear = 1'b1;
        end
        busy_d = (state_d == ST_SHIFT);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shiftReg_q <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

`ifdef SERIAL_SUM_PARITY_EN
    logic parity_q, parity_d;
    logic parityErr_q, parityErr_d;
    logic parityChk_q, parityChk_d;

    // Parity is loaded with the word; the check fires once, on the first
    // edge spent in HOLD.
    always_comb begin
        parity_d    = parity_q;
        parityErr_d = parityErr_q;
        parityChk_d = 1'b0;
        if (state_q == ST_SHIFT && cntLast) begin
            parity_d    = ^shifted;
            parityChk_d = 1'b1;
        end
        if (parityChk_q && state_q == ST_HOLD && outValid_q && parity_in != parity_q) begin
            parityErr_d = 1'b1;
        end
    end

    // Parity registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q    <= 1'b0;
            parityErr_q <= 1'b0;
            parityChk_q <= 1'b0;
        end else begin
            parity_q    <= parity_d;
            parityErr_q <= parityErr_d;
            parityChk_q <= parityChk_d;
        end
    end

    assign parity     = parity_q;
    assign parity_err = parityErr_q;
`endif

endmodule

// File: tb/tb_serial_sum_collector.sv
// tb_serial_sum_collector
// Directed bench for serial_sum_collector with reglength=3 (4-bit words).
// Inputs change 1 time unit after a posedge; outputs are checked there too.
// Define SERIAL_SUM_PARITY_EN to also exercise the parity ports.
module tb_serial_sum_collector;

    localparam int RL = 3;

    logic           clk;
    logic           rst;
    logic           start;
    logic           sum_in;
    logic           out_ready;
    logic [RL:0]    out_data;
    logic           out_valid;
    logic           busy;
    logic           overrun;
`ifdef SERIAL_SUM_PARITY_EN
    logic           parity_in;
    logic           parity;
    logic           parity_err;
`endif

    int checks;
    int failures;

    serial_sum_collector #(
        .reglength(RL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sum_in   (sum_in),
        .out_ready(out_ready),
`ifdef SERIAL_SUM_PARITY_EN
        .parity_in (parity_in),
        .parity    (parity),
        .parity_err(parity_err),
`endif
        .out_data (out_data),
        .out_valid(out_valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point; counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream a 4-bit word LSB first starting with start; checks busy while
    // shifting and the presented word afterwards.
    task automatic applyStimulus(input logic [3:0] word);
        for (int i = 0; i < 4; i++) begin
            start  = (i == 0);
            sum_in = word[i];
            tick();
            if (i < 3) begin
                checkOutput("busy_shift", busy, 1'b1);
                checkOutput("valid_shift", out_valid, 1'b0);
            end
        end
        start  = 1'b0;
        sum_in = 1'b0;
        checkOutput("valid_word", out_valid, 1'b1);
        checkOutput("busy_hold", busy, 1'b0);
        checkOutput("data_word", out_data, word);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        sum_in    = 1'b0;
        out_ready = 1'b0;
`ifdef SERIAL_SUM_PARITY_EN
        parity_in = 1'b0;
`endif
        tick();
        tick();
        checkOutput("rst_valid", out_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_overrun", overrun, 1'b0);
        checkOutput("rst_data", out_data, 4'b0000);
        rst = 1'b0;
        tick();
        checkOutput("idle_busy", busy, 1'b0);

        // Basic word 5+6=11 and backpressure.
        applyStimulus(4'b1011);
        checkOutput("basic_overrun", overrun, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_valid", out_valid, 1'b1);
            checkOutput("bp_data", out_data, 4'b1011);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("accept_valid", out_valid, 1'b0);
        checkOutput("accept_data_kept", out_data, 4'b1011);
        checkOutput("accept_busy", busy, 1'b0);

        // Back-to-back: new start together with the handshake.
        applyStimulus(4'b1011);
        out_ready = 1'b1;
        start     = 1'b1;
        sum_in    = 1'b0;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        checkOutput("b2b_valid_drop", out_valid, 1'b0);
        checkOutput("b2b_busy", busy, 1'b1);
        sum_in = 1'b0; tick();
        sum_in = 1'b1; tick();
        checkOutput("b2b_mid_valid", out_valid, 1'b0);
        sum_in = 1'b0; tick();
        checkOutput("b2b_valid", out_valid, 1'b1);
        checkOutput("b2b_data", out_data, 4'b0100);
        checkOutput("b2b_overrun", overrun, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("b2b_accept", out_valid, 1'b0);

        // Reset after two bits of a capture.
        start = 1'b1; sum_in = 1'b1; tick();
        start = 1'b0; sum_in = 1'b0; tick();
        checkOutput("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        checkOutput("midrst_valid", out_valid, 1'b0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_overrun", overrun, 1'b0);
        checkOutput("midrst_data", out_data, 4'b0000);
        rst = 1'b0;
        tick();
        checkOutput("midrst_idle_valid", out_valid, 1'b0);
        applyStimulus(4'b1011);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Overrun: start during SHIFT, then start in HOLD without ready.
        start = 1'b1; sum_in = 1'b1; tick();
        start = 1'b0; sum_in = 1'b1; tick();
        checkOutput("ovr_before", overrun, 1'b0);
        start = 1'b1; sum_in = 1'b0; tick();
        checkOutput("ovr_shift", overrun, 1'b1);
        checkOutput("ovr_shift_busy", busy, 1'b1);
        start = 1'b0; sum_in = 1'b1; tick();
        checkOutput("ovr_word_valid", out_valid, 1'b1);
        checkOutput("ovr_word_data", out_data, 4'b1011);
        start = 1'b1; sum_in = 1'b0; tick();
        start = 1'b0;
        checkOutput("ovr_hold", overrun, 1'b1);
        checkOutput("ovr_hold_valid", out_valid, 1'b1);
        checkOutput("ovr_hold_busy", busy, 1'b0);
        checkOutput("ovr_hold_data", out_data, 4'b1011);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("ovr_sticky", overrun, 1'b1);
        checkOutput("ovr_accept", out_valid, 1'b0);

`ifdef SERIAL_SUM_PARITY_EN
        // Parity: word 1011 has odd weight, parity=1.
        rst = 1'b1; tick(); rst = 1'b0;
        checkOutput("par_rst", parity, 1'b0);
        parity_in = 1'b0;
        applyStimulus(4'b1011);
        checkOutput("par_value", parity, 1'b1);
        tick();
        checkOutput("par_err_set", parity_err, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        checkOutput("par_err_rst", parity_err, 1'b0);
        parity_in = 1'b1;
        applyStimulus(4'b1011);
        tick();
        checkOutput("par_err_clean", parity_err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
